regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 74 +++++++
 tb/tb_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Two-read, one-write architectural register file.
// r0 is hardwired to zero; reads bypass a same-cycle write.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [DEPTH];

  logic wr_ok;
  logic hit1;
  logic hit2;

  assign wr_ok = we && (waddr != '0);
  assign hit1  = wr_ok && (waddr == raddr1);
  assign hit2  = wr_ok && (waddr == raddr2);

  // Storage: reset clears every entry, writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Port 1: reset, disable and r0 force zero; then bypass, then array.
  always_comb begin
    rdata1 = '0;
    if (rst) begin
      rdata1 = '0;
    end else if (!re1) begin
      rdata1 = '0;
    end else if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (hit1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Port 2: same priority as port 1, fully independent.
  always_comb begin
    rdata2 = '0;
    if (rst) begin
      rdata2 = '0;
    end else if (!re2) begin
      rdata2 = '0;
    end else if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (hit2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed cases plus
// randomized traffic against an array-based reference.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    string       name;
  } exp_t;

  exp_t q[$];
  event sample_ev;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  function automatic logic [31:0] ref_rd(
    input logic       en,
    input logic [4:0] a
  );
    if (rst || !en || a == 5'd0) return 32'h0;
    if (we && waddr != 5'd0 && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic cyc(
    input logic        r,
    input logic        w,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic        e1,
    input logic [4:0]  a1,
    input logic        e2,
    input logic [4:0]  a2,
    input string       nm
  );
    exp_t e;
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #2;
    e.r1 = ref_rd(re1, raddr1);
    e.r2 = ref_rd(re2, raddr2);
    e.name = nm;
    q.push_back(e);
    ->sample_ev;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  always begin
    exp_t e;
    @(sample_ev);
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got none, need one entry");
    end else begin
      e = q.pop_front();
      checks++;
      if (rdata1 !== e.r1) begin
        errors++;
        $display("FAIL %s rdata1: got %h need %h",
                 e.name, rdata1, e.r1);
      end
      checks++;
      if (rdata2 !== e.r2) begin
        errors++;
        $display("FAIL %s rdata2: got %h need %h",
                 e.name, rdata2, e.r2);
      end
    end
  end

  initial begin
    logic        r, w, e1, e2;
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cyc(1, 1, 5'd3, 32'h1, 1, 5'd3, 1, 5'd3, "reset_out");
    cyc(1, 0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd2, "reset_hold");
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, "rst_clr_wr");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, "rst_clr_pre");
    cyc(1, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, "rst_clr_in");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, "rst_clr_r5");
    cyc(0, 1, 5'd3, 32'h12345678, 0, 5'd0, 0, 5'd0, "basic_wr");
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd3, "basic_rd");
    cyc(0, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 1, 5'd7, "bypass");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, "bypass_next");
    cyc(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, "r0_wr");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, "r0_next");
    cyc(0, 1, 5'd9, 32'h00000055, 0, 5'd0, 0, 5'd0, "gate_wr");
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd9, 1, 5'd9, "gate_off");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd9, "gate_on");
    cyc(0, 1, 5'd4, 32'h0BADF00D, 1, 5'd3, 1, 5'd4, "nomatch");
    cyc(0, 1, 5'd4, 32'h22222222, 1, 5'd4, 1, 5'd4, "b2b_1");
    cyc(0, 1, 5'd4, 32'h33333333, 1, 5'd4, 1, 5'd4, "b2b_2");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd9, "b2b_last");
    cyc(1, 1, 5'd4, 32'h11111111, 1, 5'd4, 1, 5'd4, "rst_prio");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd9, "rst_prio_r4");
    cyc(0, 1, 5'd6, 32'hCAFE0001, 0, 5'd0, 0, 5'd0, "first_wr");
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd6, 1, 5'd6, "first_rd");
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      w  = $urandom_range(0, 1);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      e1 = ($urandom_range(0, 5) != 0);
      e2 = ($urandom_range(0, 5) != 0);
      a1 = $urandom_range(0, 1) ? wa : 5'($urandom_range(0, 31));
      a2 = $urandom_range(0, 1) ? a1 : 5'($urandom_range(0, 31));
      cyc(r, w, wa, wd, e1, a1, e2, a2, "random");
    end
    #10;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left, need 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
